// File: rtl/servo_pulse_capture_pkg.sv
// Shared types and register-map constants for the servo pulse capture block.
package servo_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_LOST = 2'd3
  } cap_state_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_HIGH   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STATUS_NEW_BIT  = 0;
  localparam int STATUS_LOST_BIT = 1;
  localparam int STATUS_CNT_LSB  = 8;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_CLR_BIT    = 2;

endpackage

// File: rtl/servo_pulse_capture_if.sv
// Avalon-MM slave bus (read latency 1) plus interrupt line of the pulse capture block.
interface servo_pulse_capture_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );
endinterface

// File: rtl/pulse_sync_edge.sv
// Synchronizer chain plus edge detector producing one-cycle rise/fall pulses.
// Edges are suppressed until the chain holds post-reset samples, so a pin already high at reset is not a rise.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES:0]   vld_r;
  logic                   prev_r;
  logic                   rise_r;
  logic                   fall_r;

  // synchronize, track valid fill and register the edge pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_r <= '0;
      vld_r  <= '0;
      prev_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      vld_r  <= {vld_r[SYNC_STAGES-1:0], 1'b1};
      prev_r <= sync_r[SYNC_STAGES-1];
      rise_r <= vld_r[SYNC_STAGES] & sync_r[SYNC_STAGES-1] & ~prev_r;
      fall_r <= vld_r[SYNC_STAGES] & ~sync_r[SYNC_STAGES-1] & prev_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/servo_pulse_capture.sv
// Measures PWM high time and period in clk cycles; results exposed on an Avalon-MM slave.
module servo_pulse_capture
  import servo_capture_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int TIMEOUT     = 2500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pwm_in,
  servo_pulse_capture_if.slave  avs
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return CNT_MAX;
    else              return v + CNT_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_W]) return CNT_MAX;
    else            return sum[CNT_W-1:0];
  endfunction

  logic rise_s, fall_s;

  pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (pwm_in),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  cap_state_e       state_r, state_s;
  logic [CNT_W-1:0] hi_cnt_r, hi_cnt_s, lo_cnt_r, lo_cnt_s, idle_cnt_r, idle_cnt_s;
  logic [CNT_W-1:0] high_r, high_s, period_r, period_s;
  logic [7:0]       sample_cnt_r, sample_cnt_s;
  logic             new_flag_r, new_flag_s, lost_r, lost_s;
  logic             enable_r, enable_s, irq_en_r, irq_en_s, irq_r, irq_s;
  logic [31:0]      readdata_r, readdata_s, rd_word_s;
  logic             status_rd_s, ctrl_wr_s, clr_s, timeout_s;
  logic             publish_s, lost_set_s, lost_rel_s;
  logic             unused_wd_s;

  assign unused_wd_s = ^avs.avs_writedata[31:3];

  // capture FSM, counters and the published result registers
  always_comb begin
    status_rd_s = avs.avs_read & (avs.avs_address == ADDR_STATUS);
    ctrl_wr_s   = avs.avs_write & (avs.avs_address == ADDR_CTRL);
    clr_s       = ctrl_wr_s & avs.avs_writedata[CTRL_CLR_BIT];
    timeout_s   = enable_r & (idle_cnt_r >= TIMEOUT_C);
    state_s     = state_r;
    hi_cnt_s    = hi_cnt_r;
    lo_cnt_s    = lo_cnt_r;
    publish_s   = 1'b0;
    lost_set_s  = 1'b0;
    lost_rel_s  = 1'b0;

    if (!enable_r) begin
      state_s  = ST_IDLE;
      hi_cnt_s = '0;
      lo_cnt_s = '0;
    end else if (timeout_s && (state_r != ST_LOST)) begin
      state_s    = ST_LOST;
      hi_cnt_s   = '0;
      lo_cnt_s   = '0;
      lost_set_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_s  = ST_HIGH;
            hi_cnt_s = CNT_ONE;
            lo_cnt_s = '0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (fall_s) begin
            state_s  = ST_LOW;
            lo_cnt_s = CNT_ONE;
          end else begin
            hi_cnt_s = sat_inc(hi_cnt_r);
          end
        end
        ST_LOW: begin
          if (rise_s) begin
            publish_s = 1'b1;
            state_s   = ST_HIGH;
            hi_cnt_s  = CNT_ONE;
            lo_cnt_s  = '0;
          end else begin
            lo_cnt_s = sat_inc(lo_cnt_r);
          end
        end
        ST_LOST: begin
          if (rise_s) begin
            state_s    = ST_HIGH;
            hi_cnt_s   = CNT_ONE;
            lo_cnt_s   = '0;
            lost_rel_s = 1'b1;
          end else begin
            state_s = ST_LOST;
          end
        end
        default: begin
          state_s  = ST_IDLE;
          hi_cnt_s = '0;
          lo_cnt_s = '0;
        end
      endcase
    end

    // idle_cnt saturates at TIMEOUT so LOST stays asserted without wrapping
    if (!enable_r || rise_s || fall_s) idle_cnt_s = '0;
    else if (idle_cnt_r < TIMEOUT_C)   idle_cnt_s = idle_cnt_r + CNT_ONE;
    else                               idle_cnt_s = idle_cnt_r;

    high_s       = publish_s ? hi_cnt_r : high_r;
    period_s     = publish_s ? sat_add(hi_cnt_r, lo_cnt_r) : period_r;
    sample_cnt_s = publish_s ? (sample_cnt_r + 8'd1) : sample_cnt_r;
    new_flag_s   = publish_s | (new_flag_r & ~(status_rd_s | clr_s));

    if (lost_set_s)      lost_s = 1'b1;
    else if (lost_rel_s) lost_s = 1'b0;
    else if (clr_s)      lost_s = 1'b0;
    else                 lost_s = lost_r;

    if (ctrl_wr_s) begin
      enable_s = avs.avs_writedata[CTRL_EN_BIT];
      irq_en_s = avs.avs_writedata[CTRL_IRQ_EN_BIT];
    end else begin
      enable_s = enable_r;
      irq_en_s = irq_en_r;
    end

    irq_s = new_flag_s & irq_en_s;
  end

  // read mux over current (pre-update) register values
  always_comb begin
    rd_word_s = 32'h0000_0000;
    case (avs.avs_address)
      ADDR_STATUS: begin
        rd_word_s[STATUS_NEW_BIT]          = new_flag_r;
        rd_word_s[STATUS_LOST_BIT]         = lost_r;
        rd_word_s[STATUS_CNT_LSB +: 8]     = sample_cnt_r;
      end
      ADDR_HIGH:   rd_word_s = 32'(high_r);
      ADDR_PERIOD: rd_word_s = 32'(period_r);
      ADDR_CTRL: begin
        rd_word_s[CTRL_EN_BIT]     = enable_r;
        rd_word_s[CTRL_IRQ_EN_BIT] = irq_en_r;
      end
      default:     rd_word_s = 32'h0000_0000;
    endcase
    readdata_s = avs.avs_read ? rd_word_s : readdata_r;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      hi_cnt_r     <= '0;
      lo_cnt_r     <= '0;
      idle_cnt_r   <= '0;
      high_r       <= '0;
      period_r     <= '0;
      sample_cnt_r <= 8'd0;
      new_flag_r   <= 1'b0;
      lost_r       <= 1'b0;
      enable_r     <= 1'b1;
      irq_en_r     <= 1'b0;
      readdata_r   <= 32'h0000_0000;
      irq_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      hi_cnt_r     <= hi_cnt_s;
      lo_cnt_r     <= lo_cnt_s;
      idle_cnt_r   <= idle_cnt_s;
      high_r       <= high_s;
      period_r     <= period_s;
      sample_cnt_r <= sample_cnt_s;
      new_flag_r   <= new_flag_s;
      lost_r       <= lost_s;
      enable_r     <= enable_s;
      irq_en_r     <= irq_en_s;
      readdata_r   <= readdata_s;
      irq_r        <= irq_s;
    end
  end

  assign avs.avs_readdata = readdata_r;
  assign avs.irq          = irq_r;

endmodule

// File: tb/tb_servo_pulse_capture.sv
// Directed bench for servo_pulse_capture with scaled-down TIMEOUT and pulse widths.
module tb_servo_pulse_capture;
  import servo_capture_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic pwm_in;
  int   n_checks = 0;
  int   n_errors = 0;
  int   since_fall = 0;
  logic [31:0] rdata;

  servo_pulse_capture_if bus ();

  servo_pulse_capture #(.CNT_W(16), .TIMEOUT(400), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pwm_in  (pwm_in),
    .avs     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    since_fall++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fall();
    pwm_in = 1'b0;
    since_fall = 0;
  endtask

  task automatic pwm_cycle(input int h, input int p);
    pwm_in = 1'b1;
    ticks(h);
    fall();
    ticks(p - h);
  endtask

  task automatic rd(input logic [1:0] addr);
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read    = 1'b0;
    rdata           = bus.avs_readdata;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    rd(addr);
    chk(tag, rdata, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    pwm_in = 1'b0;
    bus.avs_address = 2'd0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = 32'h0;
    ticks(3);
    reset_n = 1'b1;
    chk("rst_readdata", bus.avs_readdata, 32'h0);
    chk("rst_irq", {31'd0, bus.irq}, 32'h0);
    rd_chk("rst_status", ADDR_STATUS, 32'h0);
    rd_chk("rst_high", ADDR_HIGH, 32'h0);
    rd_chk("rst_period", ADDR_PERIOD, 32'h0);
    rd_chk("rst_ctrl", ADDR_CTRL, 32'h1);

    // three 15/100 periods: first rise only arms
    pwm_cycle(15, 100);
    pwm_cycle(15, 100);
    pwm_cycle(15, 100);
    chk("basic_irq_off", {31'd0, bus.irq}, 32'h0);
    rd_chk("basic_status", ADDR_STATUS, 32'h0000_0201);
    rd_chk("basic_high", ADDR_HIGH, 32'd15);
    rd_chk("basic_period", ADDR_PERIOD, 32'd100);

    // interrupt path; bus accesses above stretch the low phase by 4 cycles
    wr(ADDR_CTRL, 32'h3);
    pwm_cycle(30, 120);
    chk("irq_set", {31'd0, bus.irq}, 32'h1);
    rd_chk("irq_status", ADDR_STATUS, 32'h0000_0301);
    chk("irq_cleared", {31'd0, bus.irq}, 32'h0);
    rd_chk("irq_high", ADDR_HIGH, 32'd15);
    rd_chk("irq_period", ADDR_PERIOD, 32'd104);
    pwm_cycle(30, 120);
    wr(ADDR_CTRL, 32'h1);
    rd_chk("p30_high", ADDR_HIGH, 32'd30);
    rd_chk("p30_period", ADDR_PERIOD, 32'd123);

    // signal loss: lost must rise exactly TIMEOUT cycles after the edge is seen
    while (since_fall < 404) tick();
    rd_chk("lost_before", ADDR_STATUS, 32'h0000_0401);
    rd_chk("lost_at_timeout", ADDR_STATUS, 32'h0000_0402);
    rd_chk("lost_high_held", ADDR_HIGH, 32'd30);
    rd_chk("lost_period_held", ADDR_PERIOD, 32'd123);
    pwm_cycle(10, 100);
    rd_chk("lost_cleared", ADDR_STATUS, 32'h0000_0400);
    pwm_cycle(10, 100);
    pwm_cycle(10, 100);
    rd_chk("resume_status", ADDR_STATUS, 32'h0000_0601);
    rd_chk("resume_high", ADDR_HIGH, 32'd10);
    rd_chk("resume_period", ADDR_PERIOD, 32'd100);

    // reset in the middle of a high pulse
    pwm_in = 1'b1;
    ticks(8);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_readdata", bus.avs_readdata, 32'h0);
    chk("midrst_irq", {31'd0, bus.irq}, 32'h0);
    rd_chk("midrst_status", ADDR_STATUS, 32'h0);
    rd_chk("midrst_high", ADDR_HIGH, 32'h0);
    rd_chk("midrst_period", ADDR_PERIOD, 32'h0);
    rd_chk("midrst_ctrl", ADDR_CTRL, 32'h1);
    ticks(5);
    fall();
    ticks(40);
    pwm_cycle(15, 100);
    rd_chk("midrst_no_publish", ADDR_STATUS, 32'h0);
    pwm_cycle(15, 100);
    rd_chk("midrst_high2", ADDR_HIGH, 32'd15);
    rd_chk("midrst_period2", ADDR_PERIOD, 32'd101);
    rd_chk("midrst_status2", ADDR_STATUS, 32'h0000_0101);

    // STATUS read landing on the publish cycle returns the old value
    pwm_in = 1'b1;
    ticks(3);
    rd_chk("coinc_old", ADDR_STATUS, 32'h0000_0100);
    rd_chk("coinc_new", ADDR_STATUS, 32'h0000_0201);
    ticks(10);
    fall();
    ticks(85);
    rd_chk("coinc_high", ADDR_HIGH, 32'd15);
    rd_chk("coinc_period", ADDR_PERIOD, 32'd103);

    // disable while in LOW: following rise must not publish
    wr(ADDR_CTRL, 32'h0);
    ticks(5);
    pwm_cycle(20, 100);
    rd_chk("dis_status", ADDR_STATUS, 32'h0000_0200);
    rd_chk("dis_high", ADDR_HIGH, 32'd15);
    rd_chk("dis_period", ADDR_PERIOD, 32'd103);
    wr(ADDR_CTRL, 32'h1);
    pwm_cycle(25, 90);
    pwm_cycle(25, 90);
    rd_chk("reen_status", ADDR_STATUS, 32'h0000_0301);
    rd_chk("reen_high", ADDR_HIGH, 32'd25);
    rd_chk("reen_period", ADDR_PERIOD, 32'd90);

    // CTRL clear bit is self-clearing and drops new_flag
    pwm_cycle(25, 90);
    wr(ADDR_CTRL, 32'h5);
    rd_chk("clr_status", ADDR_STATUS, 32'h0000_0400);
    rd_chk("clr_ctrl", ADDR_CTRL, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/servo_pulse_capture.md
Name: servo_pulse_capture

Overview:
- Measures an incoming servo/RC-style PWM signal, the inverse of the servo PWM generator already on the HPS lightweight bus.
- Reports high time and period in clk cycles through an Avalon-MM slave (read latency 1), with an optional interrupt on each new measurement.
- Intended for forklift feedback: servo position sense, or RC receiver input for manual override.

Parameters:
- CNT_W, 24, width of high/period counters in clk cycles; must satisfy TIMEOUT < 2^CNT_W.
- TIMEOUT, 2500000, clk cycles without any edge before the signal is declared lost (50 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop stages on pwm_in before edge detection (minimum 2).

Ports:
- clk, input, 1, system clock (50 MHz nominal).
- reset_n, input, 1, synchronous active-low reset.
- pwm_in, input, 1, asynchronous PWM input pin.
- avs_address, input, 2, word address: 0 STATUS, 1 HIGH, 2 PERIOD, 3 CTRL.
- avs_read, input, 1, read strobe.
- avs_write, input, 1, write strobe.
- avs_writedata, input, 32, write data.
- avs_readdata, output, 32, registered read data, valid the cycle after avs_read.
- irq, output, 1, level interrupt = new_flag AND irq_en.

Behaviour:
- Reset (reset_n = 0 at a clk edge): FSM = IDLE; all counters, HIGH, PERIOD, new_flag, lost = 0; CTRL.enable = 1, CTRL.irq_en = 0; avs_readdata = 0; irq = 0. Reset mid-pulse discards the partial measurement; the next full period is measured from a rising edge seen after reset.
- Input path: pwm_in passes through SYNC_STAGES flip-flops, then a 1-cycle edge detector. Latency is fixed and equal on both edges, so measured widths equal true edge spacing ±1 clk.
- FSM:
  - IDLE: waits for a rising edge, then goes to HIGH with hi_cnt = 1, lo_cnt = 0.
  - HIGH: hi_cnt increments (saturating). A falling edge goes to LOW with lo_cnt = 1.
  - LOW: lo_cnt increments (saturating). A rising edge publishes the measurement, then goes to HIGH with hi_cnt = 1, lo_cnt = 0.
  - LOST: entered from any state when idle_cnt reaches TIMEOUT. Sets lost = 1; HIGH and PERIOD are held. A rising edge goes to HIGH and clears lost; that first partial period is not published.
- Publish: in one cycle, HIGH = hi_cnt and PERIOD = hi_cnt + lo_cnt, computed in CNT_W bits and saturating at all-ones. new_flag is set and sample_cnt (8 bits, wraps 255 -> 0) increments.
- idle_cnt: cleared on any detected edge; otherwise increments while enable = 1; compared with >= TIMEOUT.
- enable = 0: FSM forced to IDLE; counters are held at 0; published registers, lost, and new_flag are retained.
- Register map:
  - STATUS (read): bit0 new_flag, bit1 lost, bits[15:8] sample_cnt. Reading STATUS clears new_flag.
  - HIGH (read): zero-extended HIGH.
  - PERIOD (read): zero-extended PERIOD.
  - CTRL: bit0 enable, bit1 irq_en, read/write. Writing bit2 = 1 clears new_flag and lost (self-clearing).
  - Writes to addresses 0–2 are ignored.
- Simultaneous events:
  - Publish in the same cycle as a STATUS read: the read returns the pre-publish value, and new_flag ends the cycle set. No event is lost.
  - Publish in the same cycle as a CTRL clear: set wins.
  - Read of HIGH or PERIOD in the publish cycle returns the old value.
- A coherent pair is guaranteed if software reads STATUS, then HIGH and PERIOD, then STATUS again with an unchanged sample_cnt.

Decomposition:
- Package servo_capture_pkg holds:
  - the FSM state enum (IDLE, HIGH, LOW, LOST);
  - register address constants;
  - STATUS/CTRL bit index constants.
- One sub-module: pulse_sync_edge (synchronizer plus edge detector, outputs rise/fall pulses). It is reusable for the encoder inputs.

Test Plan:
- 1.5 ms high / 20 ms period at 50 MHz, three periods -> HIGH = 75000 ±1, PERIOD = 1000000 ±1, sample_cnt = 2 (first period only arms), new_flag = 1, irq = 0.
- irq_en = 1, then read STATUS after a publish -> irq asserts on publish, deasserts the cycle after the STATUS read, readdata bit0 = 1.
- Stop toggling for 2500000 cycles -> lost = 1 exactly at the TIMEOUT cycle, HIGH/PERIOD held. Resume 1.0 ms/20 ms -> lost clears on the first rise, second publish gives HIGH = 50000.
- Assert reset_n = 0 for 1 cycle mid-HIGH -> all outputs 0, readdata 0. The next complete period measures correctly, and no publish occurs from the partial pulse.
- Force a publish coincident with a STATUS read -> read shows new_flag = 0 (old), following read shows 1, sample_cnt is correct.
- Write CTRL enable = 0 during LOW -> no publish on the next rise, registers retained. Re-enable -> normal capture resumes.
